// File: rtl/shift_reg_q_if.sv
// -----------------------------------------------------------------------------
// shift_reg_q_if
//   Bundle of the operation/data signals of the shift_reg_q queue. clk and
//   reset_n stay outside the bundle as plain ports.
//
//   Handshake: ctrl_code is a command sampled on every rising edge (there is no
//   ready; every command is accepted). read_valid is a one-cycle strobe that
//   marks the cycle in which data_read carries a newly popped/rotated word;
//   data_read holds its value while read_valid is low.
//
//   Signals (master = stimulus side, slave = queue side):
//     ctrl_code   m->s  3            operation select
//     data_in     m->s  LENGTH words  parallel load words (signed)
//     data_write  m->s  DATA_WIDTH    push word (signed)
//     data_read   s->m  DATA_WIDTH    registered popped/rotated word
//     read_valid  s->m  1             data_read updated this cycle
//     data_out    s->m  LENGTH words  storage view, index 0 = head
//     count       s->m  CNT_W         occupied words
//     full/empty  s->m  1             occupancy flags
//     overflow    s->m  1             sticky: push while full
//     underflow   s->m  1             sticky: pop while empty
//     data_sum    s->m  DATA_WIDTH+$clog2(LENGTH)  only with SHIFT_REG_Q_SUM_EN
// -----------------------------------------------------------------------------
interface shift_reg_q_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4
);
    localparam int CNT_W = $clog2(LENGTH + 1);

    logic [2:0]                   ctrl_code;
    logic signed [DATA_WIDTH-1:0] data_in  [0:LENGTH-1];
    logic signed [DATA_WIDTH-1:0] data_write;
    logic signed [DATA_WIDTH-1:0] data_read;
    logic                         read_valid;
    logic signed [DATA_WIDTH-1:0] data_out [0:LENGTH-1];
    logic [CNT_W-1:0]             count;
    logic                         full;
    logic                         empty;
    logic                         overflow;
    logic                         underflow;
`ifdef SHIFT_REG_Q_SUM_EN
    logic signed [DATA_WIDTH+$clog2(LENGTH)-1:0] data_sum;
`endif

    modport master (
        output ctrl_code, data_in, data_write,
        input  data_read, read_valid, data_out, count, full, empty,
               overflow, underflow
`ifdef SHIFT_REG_Q_SUM_EN
        , input data_sum
`endif
    );

    modport slave (
        input  ctrl_code, data_in, data_write,
        output data_read, read_valid, data_out, count, full, empty,
               overflow, underflow
`ifdef SHIFT_REG_Q_SUM_EN
        , output data_sum
`endif
    );
endinterface

// File: rtl/shift_reg_q.sv
// -----------------------------------------------------------------------------
// shift_reg_q
//   Parametrised shift-based queue with parallel load, push to tail, pop from
//   head, combined push/pop, rotate left/right and clear. All storage words are
//   visible in parallel on data_out (index 0 = head). Words are moved bit-exact.
//
//   Ports:
//     clk      in   rising-edge clock
//     reset_n  in   synchronous active-low reset (priority over ctrl_code)
//     bus      shift_reg_q_if.slave (see interface file for signal list)
//
//   ctrl_code: 000 HOLD, 001 LOAD, 010 PUSH, 011 PUSHPOP, 100 POP,
//              101 ROTL, 110 ROTR, 111 CLEAR
//
//   Optional feature (macro SHIFT_REG_Q_SUM_EN): registered signed sum of all
//   LENGTH storage words on bus.data_sum, one cycle behind the storage.
// -----------------------------------------------------------------------------
module shift_reg_q #(
    parameter int DATA_WIDTH = 8,
    parameter int LENGTH     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    shift_reg_q_if.slave     bus
);
    localparam int CNT_W = $clog2(LENGTH + 1);

    localparam logic [2:0] OP_HOLD    = 3'b000;
    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_PUSH    = 3'b010;
    localparam logic [2:0] OP_PUSHPOP = 3'b011;
    localparam logic [2:0] OP_POP     = 3'b100;
    localparam logic [2:0] OP_ROTL    = 3'b101;
    localparam logic [2:0] OP_ROTR    = 3'b110;
    localparam logic [2:0] OP_CLEAR   = 3'b111;

    logic signed [DATA_WIDTH-1:0] r_mem [0:LENGTH-1];
    logic [CNT_W-1:0]             r_count;
    logic signed [DATA_WIDTH-1:0] r_data_read;
    logic                         r_read_valid;
    logic                         r_overflow;
    logic                         r_underflow;

    logic signed [DATA_WIDTH-1:0] w_mem [0:LENGTH-1];
    logic [CNT_W-1:0]             w_count;
    logic signed [DATA_WIDTH-1:0] w_data_read;
    logic                         w_read_valid;
    logic                         w_overflow;
    logic                         w_underflow;
    logic                         w_full;
    logic                         w_empty;

    assign w_full  = (r_count == CNT_W'(LENGTH));
    assign w_empty = (r_count == '0);

    // Next-state computation for every operation.
    always_comb begin
        w_mem        = r_mem;
        w_count      = r_count;
        w_data_read  = r_data_read;
        w_read_valid = 1'b0;
        w_overflow   = r_overflow;
        w_underflow  = r_underflow;

        case (bus.ctrl_code)
            OP_HOLD: begin
            end

            OP_LOAD: begin
                for (int i = 0; i < LENGTH; i++) w_mem[i] = bus.data_in[i];
                w_count = CNT_W'(LENGTH);
            end

            OP_PUSH: begin
                if (w_full) begin
                    w_overflow = 1'b1;
                end else begin
                    // Tail slot is the first unoccupied index, i.e. count.
                    for (int i = 0; i < LENGTH; i++)
                        if (CNT_W'(i) == r_count) w_mem[i] = bus.data_write;
                    w_count = r_count + CNT_W'(1);
                end
            end

            OP_PUSHPOP: begin
                if (w_empty) begin
                    // Nothing to pop: plain push into slot 0, no strobe.
                    w_mem[0] = bus.data_write;
                    w_count  = CNT_W'(1);
                end else begin
                    w_data_read  = r_mem[0];
                    w_read_valid = 1'b1;
                    for (int i = 0; i < LENGTH - 1; i++) w_mem[i] = r_mem[i + 1];
                    w_mem[LENGTH-1] = '0;
                    // After the shift the tail slot moved down to count-1.
                    for (int i = 0; i < LENGTH; i++)
                        if (CNT_W'(i) == r_count - CNT_W'(1)) w_mem[i] = bus.data_write;
                end
            end

            OP_POP: begin
                if (w_empty) begin
                    w_underflow = 1'b1;
                end else begin
                    w_data_read  = r_mem[0];
                    w_read_valid = 1'b1;
                    for (int i = 0; i < LENGTH - 1; i++) w_mem[i] = r_mem[i + 1];
                    w_mem[LENGTH-1] = '0;
                    w_count = r_count - CNT_W'(1);
                end
            end

            // Rotations act on all LENGTH words, independent of occupancy.
            OP_ROTL: begin
                for (int i = 0; i < LENGTH; i++) w_mem[i] = r_mem[(i + 1) % LENGTH];
                w_data_read  = r_mem[0];
                w_read_valid = 1'b1;
            end

            OP_ROTR: begin
                for (int i = 0; i < LENGTH; i++) w_mem[i] = r_mem[(i + LENGTH - 1) % LENGTH];
            end

            OP_CLEAR: begin
                for (int i = 0; i < LENGTH; i++) w_mem[i] = '0;
                w_count     = '0;
                w_overflow  = 1'b0;
                w_underflow = 1'b0;
            end

            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < LENGTH; i++) r_mem[i] <= '0;
            r_count      <= '0;
            r_data_read  <= '0;
            r_read_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_mem        <= w_mem;
            r_count      <= w_count;
            r_data_read  <= w_data_read;
            r_read_valid <= w_read_valid;
            r_overflow   <= w_overflow;
            r_underflow  <= w_underflow;
        end
    end

    assign bus.data_out   = r_mem;
    assign bus.data_read  = r_data_read;
    assign bus.read_valid = r_read_valid;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.overflow   = r_overflow;
    assign bus.underflow  = r_underflow;

`ifdef SHIFT_REG_Q_SUM_EN
    localparam int SUM_W = DATA_WIDTH + $clog2(LENGTH);

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] r_sum;

    // $clog2(LENGTH) guard bits make the sum of LENGTH words overflow-free.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LENGTH; i++)
            w_sum = w_sum + {{(SUM_W-DATA_WIDTH){r_mem[i][DATA_WIDTH-1]}}, r_mem[i]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_sum <= '0;
        else          r_sum <= w_sum;
    end

    assign bus.data_sum = r_sum;
`endif

endmodule
